fifo_reader: RTL and testbench

FIFO_READER -- requirements
Module: fifo_reader

---
 rtl/fifo_pkg.sv | 23 ++
 rtl/fifo_reader_if.sv | 38 +++
 rtl/reader_buf.sv | 84 ++++++++
 rtl/fifo_reader.sv | 74 +++++++
 tb/tb_fifo_reader.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg -- shared definitions for the FIFO reader slice.
//   DEF_WIDTH / DEF_CNT_W : default data and counter widths
//   occ_t                 : 2-bit buffer occupancy (0..2)
//   room_for_pop()        : decides whether another pop can be issued
package fifo_pkg;

   localparam int DEF_WIDTH = 36;
   localparam int DEF_CNT_W = 16;

   typedef logic [1:0] occ_t;

   localparam occ_t OCC_MAX = 2'd2;

   // A new pop is safe only if the words already held, plus the one in
   // flight, minus the one leaving this cycle, leave a free slot when the
   // popped word lands one cycle from now.
   function automatic logic room_for_pop(occ_t occ, logic pop_q, logic deq);
      logic [2:0] pending;
      pending = {1'b0, occ} + {2'b00, pop_q} - {2'b00, deq};
      return pending < {1'b0, OCC_MAX};
   endfunction

endpackage

// File: rtl/fifo_reader_if.sv
// fifo_reader_if -- FIFO read side plus downstream valid/ready stream.
//   fifo_empty : FIFO empty flag (registered in the FIFO)
//   fifo_pop   : pop strobe, data returns on fifo_dout one cycle later
//   fifo_dout  : FIFO read data
//   m_valid    : downstream data valid
//   m_ready    : downstream accept
//   m_data     : downstream data
// master = the reader; slave = the FIFO/downstream environment.
interface fifo_reader_if #(
   parameter int WIDTH = fifo_pkg::DEF_WIDTH
);

   logic             fifo_empty;
   logic             fifo_pop;
   logic [WIDTH-1:0] fifo_dout;
   logic             m_valid;
   logic             m_ready;
   logic [WIDTH-1:0] m_data;

   modport master (
      input  fifo_empty,
      input  fifo_dout,
      input  m_ready,
      output fifo_pop,
      output m_valid,
      output m_data
   );

   modport slave (
      output fifo_empty,
      output fifo_dout,
      output m_ready,
      input  fifo_pop,
      input  m_valid,
      input  m_data
   );

endinterface

// File: rtl/reader_buf.sv
// reader_buf -- 2-entry in-order register buffer.
//   clk, rst   : clock, asynchronous active-high reset
//   push       : append push_data at the tail
//   pop        : drop the head (ignored when empty)
//   clear      : discard all entries (wins over push/pop)
//   occ        : number of held entries, 0..2
//   valid      : registered (occ != 0)
//   head       : registered head entry
module reader_buf
   import fifo_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   input  logic             clear,
   output occ_t             occ,
   output logic             valid,
   output logic [WIDTH-1:0] head
);

   occ_t             occ_reg, occ_next;
   logic             valid_reg;
   logic [WIDTH-1:0] head_reg, head_next;
   logic [WIDTH-1:0] tail_reg, tail_next;
   logic             pop_ok, push_ok;

   assign pop_ok  = pop && (occ_reg != 2'd0);
   // A full buffer accepts a push only when the head leaves in the same cycle.
   assign push_ok = push && ((occ_reg != OCC_MAX) || pop_ok);

   always_comb begin
      occ_next  = occ_reg;
      head_next = head_reg;
      tail_next = tail_reg;
      if (clear) begin
         occ_next = 2'd0;
      end else begin
         case ({push_ok, pop_ok})
            2'b10: begin
               if (occ_reg == 2'd0) head_next = push_data;
               else                 tail_next = push_data;
               occ_next = occ_reg + 2'd1;
            end
            2'b01: begin
               head_next = tail_reg;
               occ_next  = occ_reg - 2'd1;
            end
            2'b11: begin
               // Head advances and the new word joins behind it.
               if (occ_reg == 2'd1) begin
                  head_next = push_data;
               end else begin
                  head_next = tail_reg;
                  tail_next = push_data;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         occ_reg   <= 2'd0;
         valid_reg <= 1'b0;
         head_reg  <= '0;
         tail_reg  <= '0;
      end else begin
         occ_reg   <= occ_next;
         valid_reg <= (occ_next != 2'd0);
         head_reg  <= head_next;
         tail_reg  <= tail_next;
      end
   end

   assign occ   = occ_reg;
   assign valid = valid_reg;
   assign head  = head_reg;

endmodule

// File: rtl/fifo_reader.sv
// fifo_reader -- drains a registered-output FIFO into a valid/ready stream.
//   clk, rst  : clock, asynchronous active-high reset
//   flush     : discard buffered and in-flight words, no pop this cycle
//   bus       : fifo_reader_if.master (FIFO read side + downstream stream)
//   xfer_cnt  : completed downstream handshakes, wraps
//   drop_cnt  : words discarded by flush, wraps
module fifo_reader
   import fifo_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   fifo_reader_if.master    bus,
   output logic [CNT_W-1:0] xfer_cnt,
   output logic [CNT_W-1:0] drop_cnt
);

   occ_t             occ;
   logic             buf_valid;
   logic [WIDTH-1:0] buf_head;
   logic             pop_q;
   logic             deq;
   logic [1:0]       drop_now;
   logic [CNT_W-1:0] xfer_cnt_reg;
   logic [CNT_W-1:0] drop_cnt_reg;

   assign deq = buf_valid && bus.m_ready;

   // rst gates the pop so nothing is requested while the FIFO is resetting.
   assign bus.fifo_pop = !rst && !bus.fifo_empty && !flush &&
                         room_for_pop(occ, pop_q, deq);

   // On flush, the word handshaking this cycle counts as a transfer; the
   // rest of the buffer and any word landing now are dropped.
   always_comb begin
      drop_now = 2'd0;
      if (flush) drop_now = occ - {1'b0, deq} + {1'b0, pop_q};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pop_q        <= 1'b0;
         xfer_cnt_reg <= '0;
         drop_cnt_reg <= '0;
      end else begin
         pop_q        <= bus.fifo_pop;
         xfer_cnt_reg <= xfer_cnt_reg + CNT_W'(deq);
         drop_cnt_reg <= drop_cnt_reg + CNT_W'(drop_now);
      end
   end

   reader_buf #(
      .WIDTH (WIDTH)
   ) u_buf (
      .clk       (clk),
      .rst       (rst),
      .push      (pop_q && !flush),
      .push_data (bus.fifo_dout),
      .pop       (deq),
      .clear     (flush),
      .occ       (occ),
      .valid     (buf_valid),
      .head      (buf_head)
   );

   assign bus.m_valid = buf_valid;
   assign bus.m_data  = buf_head;
   assign xfer_cnt    = xfer_cnt_reg;
   assign drop_cnt    = drop_cnt_reg;

endmodule

// File: tb/tb_fifo_reader.sv
module tb_fifo_reader;
   import fifo_pkg::*;

   localparam int W      = 36;
   localparam int CW     = 16;
   localparam int CW_S   = 7;
   localparam int N_RAND = 1000;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            flush = 1'b0;
   logic [CW-1:0]   xfer_cnt, drop_cnt;
   logic [CW_S-1:0] xfer_cnt_s, drop_cnt_s;

   fifo_reader_if #(.WIDTH(W)) bus ();
   fifo_reader_if #(.WIDTH(W)) bus_s ();

   fifo_reader #(.WIDTH(W), .CNT_W(CW)) u_dut (
      .clk(clk), .rst(rst), .flush(flush), .bus(bus),
      .xfer_cnt(xfer_cnt), .drop_cnt(drop_cnt)
   );

   // Narrow-counter copy fed the same inputs: exercises counter wrap quickly.
   fifo_reader #(.WIDTH(W), .CNT_W(CW_S)) u_dut_s (
      .clk(clk), .rst(rst), .flush(flush), .bus(bus_s),
      .xfer_cnt(xfer_cnt_s), .drop_cnt(drop_cnt_s)
   );
   assign bus_s.fifo_empty = bus.fifo_empty;
   assign bus_s.fifo_dout  = bus.fifo_dout;
   assign bus_s.m_ready    = bus.m_ready;

   always #5 clk = ~clk;

   // FIFO model: registered empty flag, data one cycle after pop.
   logic [W-1:0] fq[$];
   int underflow = 0;
   always @(posedge clk) begin
      if (bus.fifo_pop) begin
         if (fq.size() == 0) underflow++;
         else bus.fifo_dout <= fq.pop_front();
      end
      bus.fifo_empty <= (fq.size() == 0);
   end

   int pass_cnt = 0;
   int total_cnt = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic do_reset(input int n, input logic [W-1:0] base);
      @(negedge clk);
      rst = 1'b1;
      flush = 1'b0;
      bus.m_ready = 1'b0;
      fq.delete();
      for (int i = 0; i < n; i++) fq.push_back(base + W'(i));
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   typedef struct {
      bit           start;
      int           nload;
      logic [W-1:0] base;
      bit           ready;
      bit           flush;
      bit           e_pop;
      bit           e_valid;
      bit           chk_data;
      logic [W-1:0] e_data;
      int           e_xfer;
      int           e_drop;
   } vec_t;
   vec_t vecs[$];

   function automatic void add(bit st, int nl, logic [W-1:0] bs, bit r, bit f,
                               bit p, bit v, bit cd, logic [W-1:0] d, int x, int dr);
      vec_t e;
      e.start = st; e.nload = nl; e.base = bs; e.ready = r; e.flush = f;
      e.e_pop = p; e.e_valid = v; e.chk_data = cd; e.e_data = d;
      e.e_xfer = x; e.e_drop = dr;
      vecs.push_back(e);
   endfunction

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] exp_q[$];
      logic [W-1:0] held;
      logic [63:0]  r64;
      int sent, got, cyc, occ_bad, pops;
      bit stalled;

      bus.m_ready = 1'b0;

      // ---------------- reset state with a non-empty FIFO ----------------
      do_reset(2, 36'h7);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      check("rst_pop",   bus.fifo_pop, 0);
      check("rst_valid", bus.m_valid, 0);
      check("rst_data",  bus.m_data, 0);
      check("rst_xfer",  xfer_cnt, 0);
      check("rst_drop",  drop_cnt, 0);

      // ---------------- table-driven cycle vectors ----------------
      // stall: 3 words, ready low 10 cycles, then drain
      add(1, 3, 36'h0A, 0, 0, 1, 0, 0, 0, 0, 0);
      add(0, 0, 0,      0, 0, 1, 0, 0, 0, 0, 0);
      for (int k = 2; k <= 9; k++) add(0, 0, 0, 0, 0, 0, 1, 1, 36'h0A, 0, 0);
      add(0, 0, 0, 1, 0, 1, 1, 1, 36'h0A, 0, 0);
      add(0, 0, 0, 1, 0, 0, 1, 1, 36'h0B, 1, 0);
      add(0, 0, 0, 1, 0, 0, 1, 1, 36'h0C, 2, 0);
      add(0, 0, 0, 1, 0, 0, 0, 0, 0,      3, 0);
      // flush one cycle after a pop from empty buffer: in-flight word dropped
      add(1, 1, 36'h55, 1, 0, 1, 0, 0, 0, 0, 0);
      add(0, 0, 0,      1, 1, 0, 0, 0, 0, 0, 0);
      add(0, 0, 0,      1, 0, 0, 0, 0, 0, 0, 1);
      add(0, 0, 0,      1, 0, 0, 0, 0, 0, 0, 1);
      // full buffer, flush with ready high, then resume
      add(1, 3, 36'h21, 0, 0, 1, 0, 0, 0, 0, 0);
      add(0, 0, 0,      0, 0, 1, 0, 0, 0, 0, 0);
      add(0, 0, 0,      0, 0, 0, 1, 1, 36'h21, 0, 0);
      add(0, 0, 0,      0, 0, 0, 1, 1, 36'h21, 0, 0);
      add(0, 0, 0,      1, 1, 0, 1, 1, 36'h21, 0, 0);
      add(0, 0, 0,      1, 0, 1, 0, 0, 0,      1, 1);
      add(0, 0, 0,      1, 0, 0, 0, 0, 0,      1, 1);
      add(0, 0, 0,      1, 0, 0, 1, 1, 36'h23, 1, 1);
      add(0, 0, 0,      1, 0, 0, 0, 0, 0,      2, 1);

      for (int i = 0; i < vecs.size(); i++) begin
         if (vecs[i].start) do_reset(vecs[i].nload, vecs[i].base);
         else @(negedge clk);
         bus.m_ready = vecs[i].ready;
         flush = vecs[i].flush;
         #1;
         check($sformatf("vec%0d_pop", i),   bus.fifo_pop, vecs[i].e_pop);
         check($sformatf("vec%0d_valid", i), bus.m_valid, vecs[i].e_valid);
         if (vecs[i].chk_data) check($sformatf("vec%0d_data", i), bus.m_data, vecs[i].e_data);
         check($sformatf("vec%0d_xfer", i), xfer_cnt, vecs[i].e_xfer);
         check($sformatf("vec%0d_drop", i), drop_cnt, vecs[i].e_drop);
      end
      flush = 1'b0;

      // ---------------- streaming 1..8 with ready high ----------------
      do_reset(8, 36'h1);
      pops = 0;
      for (int k = 0; k < 12; k++) begin
         if (k > 0) @(negedge clk);
         bus.m_ready = 1'b1;
         #1;
         pops += int'(bus.fifo_pop);
         check($sformatf("stream%0d_valid", k), bus.m_valid, (k >= 2 && k <= 9));
         if (k >= 2 && k <= 9) check($sformatf("stream%0d_data", k), bus.m_data, k - 1);
      end
      check("stream_xfer", xfer_cnt, 8);
      check("stream_pops", pops, 8);
      check("stream_xfer_small", xfer_cnt_s, 8);

      // ---------------- random traffic vs. scoreboard ----------------
      do_reset(0, 0);
      sent = 0; got = 0; cyc = 0; occ_bad = 0; stalled = 0; held = '0;
      while (got < N_RAND && cyc < 20000) begin
         if (sent < N_RAND && $urandom_range(0, 3) != 0) begin
            r64 = {$urandom(), $urandom()};
            fq.push_back(r64[W-1:0]);
            exp_q.push_back(r64[W-1:0]);
            sent++;
         end
         bus.m_ready = 1'($urandom_range(0, 1));
         #1;
         if (u_dut.occ > 2'd2) occ_bad++;
         if (stalled) begin
            check($sformatf("hold%0d_valid", cyc), bus.m_valid, 1);
            check($sformatf("hold%0d_data", cyc), bus.m_data, held);
         end
         if (bus.m_valid && bus.m_ready) begin
            if (exp_q.size() == 0) check($sformatf("rand%0d_extra", got), 1, 0);
            else check($sformatf("rand%0d_data", got), bus.m_data, exp_q.pop_front());
            got++;
         end
         stalled = bus.m_valid && !bus.m_ready;
         held = bus.m_data;
         @(negedge clk);
         cyc++;
      end
      check("rand_done", got, N_RAND);
      bus.m_ready = 1'b1;
      repeat (5) @(negedge clk);
      #1;
      check("rand_no_extra", bus.m_valid, 0);
      check("rand_xfer", xfer_cnt, N_RAND % 65536);
      check("rand_xfer_wrap", xfer_cnt_s, N_RAND % 128);
      check("rand_occ_le_2", occ_bad, 0);
      check("rand_underflow", underflow, 0);
      check("rand_drop", drop_cnt, 0);

      // ---------------- flush of a full buffer ----------------
      @(negedge clk);
      bus.m_ready = 1'b0;
      for (int i = 0; i < 3; i++) fq.push_back(36'h100 + W'(i));
      repeat (5) @(negedge clk);
      #1;
      check("full_occ", u_dut.occ, 2);
      @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      #1;
      check("flush_valid", bus.m_valid, 0);
      check("flush_drop", drop_cnt, 2);
      check("flush_drop_small", drop_cnt_s, 2);

      // ---------------- asynchronous reset mid-stream ----------------
      for (int i = 0; i < 3; i++) fq.push_back(36'h200 + W'(i));
      repeat (5) @(negedge clk);
      #1;
      check("pre_rst_valid", bus.m_valid, 1);
      check("pre_rst_occ", u_dut.occ, 2);
      bus.m_ready = 1'b1;
      #2;
      rst = 1'b1;
      #1;
      check("arst_valid", bus.m_valid, 0);
      check("arst_pop", bus.fifo_pop, 0);
      check("arst_xfer", xfer_cnt, 0);
      check("arst_drop", drop_cnt, 0);
      check("arst_data", bus.m_data, 0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
